// File: rtl/morse_keyer.sv
// ASCII-to-Morse keyer: accepts one character per valid/ready handshake and
// drives an on/off key timed from a single unit length.
module morse_keyer #(
   parameter int unsigned UNIT_CYCLES = 2_400_000
) (
   input  logic       clk_24,
   input  logic       rst_n,
   input  logic [7:0] char_data,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key,
   output logic       busy
);

   localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int unsigned EW = 5;
   localparam int unsigned LW = 3;
   localparam int unsigned UW = 3;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      ESPACE,
      LGAP,
      WGAP
   } state_t;

   state_t          state, state_d;
   logic            key_d, busy_d;
   logic [EW-1:0]   elems, elems_d;
   logic [LW-1:0]   remain, remain_d;
   logic [CW-1:0]   cyc, cyc_d;
   logic [UW-1:0]   units, units_d;

   logic [LW+EW-1:0] code;
   logic [LW-1:0]    code_len;
   logic [EW-1:0]    code_pat;
   logic             is_space;
   logic             tick;
   logic [UW-1:0]    last_unit;
   logic             done;

   // Code table: {length, elements left-aligned, first element in the MSB, 1 = dash}
   function automatic logic [LW+EW-1:0] lookup(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
      case (u)
         "A": lookup = {3'd2, 5'b01000};
         "B": lookup = {3'd4, 5'b10000};
         "C": lookup = {3'd4, 5'b10100};
         "D": lookup = {3'd3, 5'b10000};
         "E": lookup = {3'd1, 5'b00000};
         "F": lookup = {3'd4, 5'b00100};
         "G": lookup = {3'd3, 5'b11000};
         "H": lookup = {3'd4, 5'b00000};
         "I": lookup = {3'd2, 5'b00000};
         "J": lookup = {3'd4, 5'b01110};
         "K": lookup = {3'd3, 5'b10100};
         "L": lookup = {3'd4, 5'b01000};
         "M": lookup = {3'd2, 5'b11000};
         "N": lookup = {3'd2, 5'b10000};
         "O": lookup = {3'd3, 5'b11100};
         "P": lookup = {3'd4, 5'b01100};
         "Q": lookup = {3'd4, 5'b11010};
         "R": lookup = {3'd3, 5'b01000};
         "S": lookup = {3'd3, 5'b00000};
         "T": lookup = {3'd1, 5'b10000};
         "U": lookup = {3'd3, 5'b00100};
         "V": lookup = {3'd4, 5'b00010};
         "W": lookup = {3'd3, 5'b01100};
         "X": lookup = {3'd4, 5'b10010};
         "Y": lookup = {3'd4, 5'b10110};
         "Z": lookup = {3'd4, 5'b11000};
         "0": lookup = {3'd5, 5'b11111};
         "1": lookup = {3'd5, 5'b01111};
         "2": lookup = {3'd5, 5'b00111};
         "3": lookup = {3'd5, 5'b00011};
         "4": lookup = {3'd5, 5'b00001};
         "5": lookup = {3'd5, 5'b00000};
         "6": lookup = {3'd5, 5'b10000};
         "7": lookup = {3'd5, 5'b11000};
         "8": lookup = {3'd5, 5'b11100};
         "9": lookup = {3'd5, 5'b11110};
         default: lookup = '0;
      endcase
   endfunction

   assign code     = lookup(char_data);
   assign code_len = code[LW+EW-1:EW];
   assign code_pat = code[EW-1:0];
   assign is_space = (char_data == 8'h20);

   assign char_ready = (state == IDLE);
   assign tick       = (cyc == CW'(UNIT_CYCLES - 1));
   assign done       = tick && (units == last_unit);

   // Number of units in the current state, minus one
   always_comb begin
      last_unit = '0;
      case (state)
         MARK:    last_unit = elems[EW-1] ? UW'(2) : UW'(0);
         ESPACE:  last_unit = UW'(0);
         LGAP:    last_unit = UW'(2);
         WGAP:    last_unit = UW'(3);
         default: last_unit = UW'(0);
      endcase
   end

   always_ff @(posedge clk_24 or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         key    <= 1'b0;
         busy   <= 1'b0;
         elems  <= '0;
         remain <= '0;
         cyc    <= '0;
         units  <= '0;
      end else begin
         state  <= state_d;
         key    <= key_d;
         busy   <= busy_d;
         elems  <= elems_d;
         remain <= remain_d;
         cyc    <= cyc_d;
         units  <= units_d;
      end
   end

   always_comb begin
      state_d  = state;
      key_d    = key;
      busy_d   = busy;
      elems_d  = elems;
      remain_d = remain;
      cyc_d    = tick ? '0 : cyc + CW'(1);
      units_d  = tick ? units + UW'(1) : units;

      case (state)
         IDLE: begin
            cyc_d   = '0;
            units_d = '0;
            if (char_valid) begin
               if (is_space) begin
                  state_d = WGAP;
                  busy_d  = 1'b1;
               end else if (code_len != '0) begin
                  state_d  = MARK;
                  key_d    = 1'b1;
                  busy_d   = 1'b1;
                  elems_d  = code_pat;
                  remain_d = code_len - LW'(1);
               end
            end
         end
         MARK: begin
            if (done) begin
               cyc_d   = '0;
               units_d = '0;
               key_d   = 1'b0;
               elems_d = elems << 1;
               if (remain != '0) begin
                  remain_d = remain - LW'(1);
                  state_d  = ESPACE;
               end else begin
                  state_d = LGAP;
               end
            end
         end
         ESPACE: begin
            if (done) begin
               cyc_d   = '0;
               units_d = '0;
               key_d   = 1'b1;
               state_d = MARK;
            end
         end
         LGAP, WGAP: begin
            if (done) begin
               cyc_d   = '0;
               units_d = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            key_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Converts a stream of ASCII characters (from the serial receive path) into an on/off Morse keying signal.
- The keying signal drives the `vol` input of the tone generator stage.
- Runs from the 24 MHz clock and times dots, dashes and gaps from a single unit length.
- Accepts one character at a time over a valid/ready handshake and stalls upstream while sending.

Parameters:
- UNIT_CYCLES, 2_400_000, clock cycles per Morse unit (100 ms at 24 MHz, 12 WPM); must be >= 1.

Ports:
- clk_24  input  1  24 MHz clock.
- rst_n  input  1  asynchronous active-low reset.
- char_data  input  8  ASCII character to send.
- char_valid  input  1  char_data is valid.
- char_ready  output  1  keyer can accept a character this cycle.
- key  output  1  1 = tone on; connects to tone generator vol.
- busy  output  1  1 while a character or gap is being sent.

Behaviour:
- Reset (rst_n low, asynchronous): key=0, busy=0, char_ready=1, state=IDLE, all counters 0. Takes effect immediately, including mid-element.
- Handshake: transfer occurs on a rising edge with char_valid && char_ready. char_ready = (state==IDLE), so it is combinational from the registered state. char_data is sampled only at transfer.
- Encoding (combinational lookup at transfer):
  - A-Z and a-z are case-insensitive.
  - 0-9 and space (0x20) are supported.
  - Each code is a length (1-5) plus up to 5 elements sent first-to-last; element bit 1=dash, 0=dot. Standard ITU table, e.g. E=., T=-, A=.-, 0=-----, 5=......
- Unsupported codes are accepted and discarded. State stays IDLE, char_ready stays 1, key stays 0.
- States: IDLE, MARK, ESPACE, LGAP, WGAP.
- IDLE:
  - Transfer of a letter or digit: load element shift register and remaining count, go to MARK, set key=1 at the same edge. key is high in the first cycle after the transfer edge.
  - Transfer of a space: go to WGAP, key stays 0.
- MARK: key=1 for exactly UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash) cycles.
  - If elements remain: go to ESPACE.
  - Otherwise: go to LGAP.
  - key falls at the same edge as the state change.
- ESPACE: key=0 for UNIT_CYCLES cycles, then MARK for the next element with key=1.
- LGAP: key=0 for 3*UNIT_CYCLES cycles, then IDLE.
- WGAP: key=0 for 4*UNIT_CYCLES cycles, then IDLE. A letter gap plus a space gives the standard 7-unit word gap.
- Timing counters:
  - cycle counter runs 0..UNIT_CYCLES-1 and wraps, producing a unit tick.
  - unit counter runs 3 bits, 0..4 units remaining.
  - Counters reset to 0 on every state entry. No cumulative drift.
- busy = (state != IDLE), registered with state.
- With back-to-back valid characters, the next transfer occurs in the first IDLE cycle. No extra idle cycle is inserted beyond char_ready being high for at least one cycle.
- char_valid asserted while char_ready=0 has no effect. Data is not latched.
- key only changes on state transitions; no glitches.

Test Plan (UNIT_CYCLES=4):
- Send 'E' after reset → key high cycles 1-4 after transfer, low for 12 cycles, char_ready returns high on cycle 17, busy high cycles 1-16.
- Send 'A' then 'a' back-to-back → each produces key pattern high 4, low 4, high 12, low 12. Second transfer on the first ready cycle; identical waveforms.
- Send '0' → five marks of 12 cycles separated by 4-cycle gaps, then a 12-cycle gap. Total busy = 60+16+12 = 88 cycles.
- Send 'T', ' ', 'T' → mark 12, off 12 (letter gap), off 16 (word gap, key never high, busy high), mark 12. Key low between marks for exactly 28 cycles.
- Send '#' (0x23) → accepted, char_ready stays 1, busy and key stay 0. A following 'E' is sent normally next cycle.
- Assert rst_n low mid-dash of 'T' (cycle 6 of mark) → key=0 and busy=0 asynchronously, char_ready=1. After release, sending 'E' gives a correct 4-cycle mark.
